// File: rtl/onehot_rr_encoder_if.sv
// Output stream of onehot_rr_encoder: the binary event index with a valid/ready handshake.
// The encoder drives the master side and the downstream consumer drives the slave side.
interface onehot_rr_encoder_if #(
    parameter int N = 4
);
    logic [N-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;

    modport master (output out_idx, output out_valid, input out_ready);
    modport slave  (input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/onehot_rr_encoder.sv
// Latches one-hot decoder events into a pending vector and serves them round-robin as a valid/ready index stream.
// Optional macro ONEHOT_CHECK_EN drops multi-hot input cycles and raises a sticky err flag.
module onehot_rr_encoder #(
    parameter int N = 4,
    parameter int M = 2**N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [M-1:0]          dec_in,
    onehot_rr_encoder_if.master   out_if,
    output logic [M-1:0]          pending,
    output logic                  overflow,
    output logic                  err
);
    typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   pending_q, pending_d;
    logic [M-1:0]   dec_in_eff;
    logic [M-1:0]   grant_mask;
    logic [M-1:0]   rot;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [N-1:0]   sel_off, sel_idx;
    logic           sel_found;
    logic           load;
    logic           overflow_q, overflow_d;
    logic           err_q, err_d;

`ifdef ONEHOT_CHECK_EN
    logic multi_hot;
    assign multi_hot  = |(dec_in & (dec_in - M'(1)));
    assign dec_in_eff = multi_hot ? '0 : dec_in;
    assign err_d      = err_q | multi_hot;
`else
    assign dec_in_eff = dec_in;
    assign err_d      = 1'b0;
`endif

    // Rotate pending so that bit 0 is the line at ptr; the lowest set bit is then the round-robin winner.
    for (genvar gi = 0; gi < M; gi++) begin : g_rot
        assign rot[gi] = pending_q[ptr_q + N'(gi)];
    end

    always_comb begin
        sel_found = 1'b0;
        sel_off   = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sel_found = 1'b1;
                sel_off   = N'(i);
            end
        end
    end

    assign sel_idx = ptr_q + sel_off;
    assign load    = (state_q == EMPTY) || out_if.out_ready;

    for (genvar gi = 0; gi < M; gi++) begin : g_grant
        assign grant_mask[gi] = load && sel_found && (sel_idx == N'(gi));
    end

    // A new event on a line being granted this cycle survives the clear.
    always_comb begin
        pending_d  = (pending_q & ~grant_mask) | dec_in_eff;
        overflow_d = |(dec_in_eff & pending_q & ~grant_mask);
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        if (load && sel_found) begin
            ptr_d = sel_idx + N'(1);
            idx_d = sel_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            pending_q  <= '0;
            ptr_q      <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (|pending_q) state_d = VALID;
            VALID:   if (out_if.out_ready) state_d = sel_found ? VALID : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_if.out_valid = (state_q == VALID);
        out_if.out_idx   = idx_q;
        pending          = pending_q;
        overflow         = overflow_q;
        err              = err_q;
    end
endmodule

// File: doc/onehot_rr_encoder.md
Name: onehot_rr_encoder

Overview:
- Downstream consumer of the 4-to-16 decoder's one-hot output `dec[M-1:0]`.
- Each asserted decoder line is an event request. The block latches events into a pending register and serves them one at a time in round-robin order.
- For each served event it presents the binary index on a valid/ready output port.
- It turns decoded one-hot events back into an ordered, flow-controlled stream of indices for the next stage.

Parameters:
- N, 4, width of output index; matches decoder input width.
- M, 2**N, number of one-hot request lines; matches decoder output width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- dec_in  input  M  one-hot event lines from decoder; a bit high in a cycle = one event on that line.
- out_idx  output  N  binary index of event being presented.
- out_valid  output  1  out_idx holds a valid event.
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready at a rising edge.
- pending  output  M  registered pending-event vector (observability).
- overflow  output  1  one-cycle pulse: an event arrived on a line whose pending bit was already set (event merged/lost).
- err  output  1  sticky multi-hot error (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, out_idx=0, out_valid=0, overflow=0, err=0, round-robin pointer ptr=0, FSM=EMPTY. All effects are immediate, without waiting for a clock edge.
- Reset mid-operation: every pending event and any presented event is discarded. No transfer is counted for the reset cycle.
- Pending update, each edge: pending_next = (pending & ~grant_mask) | dec_in_eff.
  - A set on a line wins over a clear of the same line in the same cycle; the new event is kept.
- overflow, registered: 1 for one cycle if any bit of (dec_in_eff & pending & ~grant_mask) is 1; else 0.
- FSM states:
  - EMPTY: out_valid=0. If pending!=0, go to VALID.
  - VALID: out_valid=1. If out_ready=1, go to VALID if another pending bit exists after the grant clear, else go to EMPTY. If out_ready=0, stay in VALID with out_idx stable.
- Selection (load condition = EMPTY, or VALID && out_ready):
  - Search pending starting at ptr, ascending, wrapping from M-1 to 0.
  - First set bit k: out_idx<=k, out_valid<=1, pending bit k cleared (grant_mask bit k), ptr<=(k+1) mod M.
  - Selection uses the registered pending only; dec_in of the same cycle is not eligible.
- Latency:
  - An event on dec_in at edge e appears in pending after edge e.
  - If the output is free, out_valid=1 with that index after edge e+1. Minimum latency is 2 edges.
- Throughput: one index per cycle while out_ready=1 and pending is non-empty (back-to-back, no bubble).
- Hold: while out_valid && !out_ready, out_idx and out_valid are unchanged. Pending keeps accumulating.
- Wrap: ptr=M-1 with grant at M-1 gives ptr=0.
- Full: all M pending bits set is legal. Further events on set lines produce overflow pulses.
- Empty: out_valid drops the cycle after the last transfer when pending is empty.

Optional Feature:
- Macro ONEHOT_CHECK_EN.
- Defined:
  - If dec_in has more than one bit set in a cycle, that cycle's input is ignored (dec_in_eff=0).
  - err is set and stays 1 until reset.
  - overflow is not raised for ignored cycles.
- Undefined:
  - dec_in_eff=dec_in; all set bits are ORed into pending (multi-hot accepted).
  - err is tied to 0.

Test Plan:
- Reset then idle, dec_in=0 for 5 cycles -> out_valid=0, pending=16'h0000, overflow=0, err=0. Assert rst_n=0 mid-stream with pending=16'h00F0 -> all outputs 0 immediately.
- Single event dec_in=16'h0020 for one cycle, out_ready=1 -> out_valid=1 with out_idx=5 exactly 2 edges later, for one cycle. Afterwards pending=0 and ptr=6.
- Round-robin with wrap: ptr=6 and pending=16'h8041 (lines 0, 6, 15), out_ready=1 -> out_idx sequence 6, 15, 0 on consecutive cycles, then out_valid=0.
- Backpressure: out_ready=0 with out_idx=3 held for 4 cycles while dec_in pulses 16'h0100 -> out_idx stays 3, pending bit 8 set. After out_ready=1 -> 3 then 8.
- Overflow and set-wins-clear:
  - Pending bit 2 set and not granted, dec_in=16'h0004 -> overflow=1 for one cycle.
  - Grant of line 2 while dec_in=16'h0004 -> pending bit 2 remains set; index 2 served again later.
- Macro test: with ONEHOT_CHECK_EN, dec_in=16'h0011 -> pending unchanged and err=1 sticky. Without the macro -> pending gains bits 0 and 4, err=0.
